// File: rtl/simple_logic_ff_arb.sv
// simple_logic_ff_arb
//
// Round-robin arbiter and sequencer that shares one external registered
// datapath computing (a|b)&(c|d) between two requesters. Each cycle at most
// one requester is granted, and its operands are steered onto dp_*. A tag
// pipeline that matches the datapath latency carries {valid, id} alongside
// the operation, so the result returns registered to the requester that
// issued it. A RUN/DRAIN/FLUSHED machine stops issuing and waits for the
// datapath to empty before reporting flush_done.
//
// Parameters
//   LAT        datapath latency in clock edges (1..8)
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   req0/req1            requests, held with stable operands until granted
//   a0..d0 / a1..d1      operands of requester 0 / 1
//   gnt0/gnt1            combinational grants
//   rvalid0/rvalid1      registered one-cycle result strobes
//   rdata                registered shared result
//   dp_a..dp_d           datapath operand inputs (combinational)
//   dp_out               datapath result
//   flush_req            drain request (level)
//   flush_done           registered, high while drained and flush_req high
//   inflight             registered count of issued, unreturned operations

module simple_logic_ff_arb #(
    parameter int LAT = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic       req1,
    input  logic       a0,
    input  logic       b0,
    input  logic       c0,
    input  logic       d0,
    input  logic       a1,
    input  logic       b1,
    input  logic       c1,
    input  logic       d1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       rvalid0,
    output logic       rvalid1,
    output logic       rdata,
    output logic       dp_a,
    output logic       dp_b,
    output logic       dp_c,
    output logic       dp_d,
    input  logic       dp_out,
    input  logic       flush_req,
    output logic       flush_done,
    output logic [3:0] inflight
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        DRAIN   = 2'd1,
        FLUSHED = 2'd2
    } state_t;

    state_t         state;
    logic           ptr;
    logic [LAT-1:0] tag_vld_p;
    logic [LAT-1:0] tag_id_p;
    logic           gnt_any;
    logic           rv_any;

    // Grants and operand mux. Grants are gated by rst_n so that every output
    // reads 0 while reset is held, even though the FSM already sits in RUN.
    // No grant is issued in the cycle flush_req is first seen.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst_n && state == RUN && !flush_req) begin
            if (req0 && req1) begin
                gnt0 = ~ptr;
                gnt1 = ptr;
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end

        dp_a = 1'b0;
        dp_b = 1'b0;
        dp_c = 1'b0;
        dp_d = 1'b0;
        if (gnt0) begin
            dp_a = a0;
            dp_b = b0;
            dp_c = c0;
            dp_d = d0;
        end else if (gnt1) begin
            dp_a = a1;
            dp_b = b1;
            dp_c = c1;
            dp_d = d1;
        end
    end

    assign gnt_any = gnt0 | gnt1;
    assign rv_any  = rvalid0 | rvalid1;

    // Stage p0..p(LAT-1): tag pipeline, aligned with the datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_vld_p <= '0;
            tag_id_p  <= '0;
        end else begin
            tag_vld_p[0] <= gnt_any;
            tag_id_p[0]  <= gnt1;
            for (int i = 1; i < LAT; i++) begin
                tag_vld_p[i] <= tag_vld_p[i-1];
                tag_id_p[i]  <= tag_id_p[i-1];
            end
        end
    end

    // Stage tail: result register; rdata holds when the tail tag is empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            rdata   <= 1'b0;
        end else begin
            rvalid0 <= tag_vld_p[LAT-1] & ~tag_id_p[LAT-1];
            rvalid1 <= tag_vld_p[LAT-1] &  tag_id_p[LAT-1];
            if (tag_vld_p[LAT-1]) begin
                rdata <= dp_out;
            end
        end
    end

    // Inflight count and round-robin pointer. An operation stays counted
    // until its rvalid strobe has been presented.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= 4'd0;
            ptr      <= 1'b0;
        end else begin
            case ({gnt_any, rv_any})
                2'b10:   inflight <= inflight + 4'd1;
                2'b01:   inflight <= inflight - 4'd1;
                default: inflight <= inflight;
            endcase
            // Pointer moves to the requester that was not served.
            if (gnt_any) begin
                ptr <= gnt0;
            end
        end
    end

    // Drain / flush control with registered flush_done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            flush_done <= 1'b0;
        end else begin
            flush_done <= 1'b0;
            case (state)
                RUN: begin
                    if (flush_req) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Empty means nothing issued and no strobe still showing.
                    if (inflight == 4'd0 && !rv_any) begin
                        state      <= FLUSHED;
                        flush_done <= flush_req;
                    end
                end
                FLUSHED: begin
                    if (!flush_req) begin
                        state <= RUN;
                    end else begin
                        flush_done <= 1'b1;
                    end
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_simple_logic_ff_arb.sv
module tb_simple_logic_ff_arb;

    localparam int LAT = 2;

    typedef struct {
        logic id;
        logic data;
        int   due;
    } exp_t;

    logic       clk;
    logic       rst_n;
    int         n_chk;
    int         n_fail;
    int         cyc;
    logic       mon_en;
    logic       allow;
    logic       mptr;
    exp_t       q[$];

    // Main instance (LAT=2)
    logic       req0, req1, flush_req;
    logic [3:0] op0, op1;
    logic       gnt0, gnt1, rvalid0, rvalid1, rdata;
    logic       dp_a, dp_b, dp_c, dp_d, dp_out, flush_done;
    logic [3:0] inflight;
    logic [1:0] dp_p;

    // Second instance (LAT=1)
    logic       req0_l1, req1_l1, flush_l1;
    logic [3:0] op0_l1, op1_l1;
    logic       gnt0_l1, gnt1_l1, rvalid0_l1, rvalid1_l1, rdata_l1;
    logic       dpa_l1, dpb_l1, dpc_l1, dpd_l1, dpout_l1, fdone_l1;
    logic [3:0] inflight_l1;

    function automatic logic fn(input logic [3:0] op);
        return (op[3] | op[2]) & (op[1] | op[0]);
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    simple_logic_ff_arb #(.LAT(LAT)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1),
        .a0(op0[3]), .b0(op0[2]), .c0(op0[1]), .d0(op0[0]),
        .a1(op1[3]), .b1(op1[2]), .c1(op1[1]), .d1(op1[0]),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
        .dp_a(dp_a), .dp_b(dp_b), .dp_c(dp_c), .dp_d(dp_d), .dp_out(dp_out),
        .flush_req(flush_req), .flush_done(flush_done), .inflight(inflight)
    );

    simple_logic_ff_arb #(.LAT(1)) u_dut_l1 (
        .clk(clk), .rst_n(rst_n),
        .req0(req0_l1), .req1(req1_l1),
        .a0(op0_l1[3]), .b0(op0_l1[2]), .c0(op0_l1[1]), .d0(op0_l1[0]),
        .a1(op1_l1[3]), .b1(op1_l1[2]), .c1(op1_l1[1]), .d1(op1_l1[0]),
        .gnt0(gnt0_l1), .gnt1(gnt1_l1), .rvalid0(rvalid0_l1), .rvalid1(rvalid1_l1), .rdata(rdata_l1),
        .dp_a(dpa_l1), .dp_b(dpb_l1), .dp_c(dpc_l1), .dp_d(dpd_l1), .dp_out(dpout_l1),
        .flush_req(flush_l1), .flush_done(fdone_l1), .inflight(inflight_l1)
    );

    // Datapath models: registered (a|b)&(c|d), no reset
    always @(posedge clk) begin
        dp_p[0]  <= (dp_a | dp_b) & (dp_c | dp_d);
        dp_p[1]  <= dp_p[0];
        dpout_l1 <= (dpa_l1 | dpb_l1) & (dpc_l1 | dpd_l1);
    end
    assign dp_out = dp_p[1];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Scoreboard monitor for the main instance, sampled on the falling edge
    initial begin : mon
        logic e0, e1, ea, eb, ec, ed;
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en && rst_n) begin
                chk("inflight", 32'(inflight), 32'(q.size()));
                if (rvalid0 || rvalid1) begin
                    chk("rv_both", 32'(rvalid0 & rvalid1), 32'd0);
                    if (q.size() == 0) begin
                        chk("rv_spurious", 32'({rvalid1, rvalid0}), 32'd0);
                    end else begin
                        e = q.pop_front();
                        chk("rv_id", 32'(rvalid1), 32'(e.id));
                        chk("rv_data", 32'(rdata), 32'(e.data));
                        chk("rv_cycle", 32'(cyc), 32'(e.due));
                    end
                end else if (q.size() > 0 && q[0].due <= cyc) begin
                    chk("rv_missing", 32'(rvalid0 | rvalid1), 32'd1);
                    void'(q.pop_front());
                end

                e0 = 1'b0;
                e1 = 1'b0;
                if (allow) begin
                    if (req0 && req1) begin
                        e0 = ~mptr;
                        e1 = mptr;
                    end else begin
                        e0 = req0;
                        e1 = req1;
                    end
                end
                chk("gnt0", 32'(gnt0), 32'(e0));
                chk("gnt1", 32'(gnt1), 32'(e1));
                {ea, eb, ec, ed} = e0 ? op0 : (e1 ? op1 : 4'b0000);
                chk("dp_ops", 32'({dp_a, dp_b, dp_c, dp_d}), 32'({ea, eb, ec, ed}));
                if (e0 || e1) begin
                    e.id   = e1;
                    e.data = e1 ? fn(op1) : fn(op0);
                    e.due  = cyc + LAT + 1;
                    q.push_back(e);
                    mptr = e0;
                end
            end
        end
    end

    initial begin
        n_chk = 0; n_fail = 0;
        mon_en = 1'b0; allow = 1'b1; mptr = 1'b0;
        req0 = 0; req1 = 0; flush_req = 0; op0 = '0; op1 = '0;
        req0_l1 = 0; req1_l1 = 0; flush_l1 = 0; op0_l1 = '0; op1_l1 = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        req0 = 1'b1;
        op0 = 4'b1111;
        #2;
        chk("rst_gnt", 32'({gnt0, gnt1}), 32'd0);
        chk("rst_dp", 32'({dp_a, dp_b, dp_c, dp_d}), 32'd0);
        chk("rst_rv", 32'({rvalid0, rvalid1, rdata}), 32'd0);
        chk("rst_fd", 32'(flush_done), 32'd0);
        chk("rst_inflight", 32'(inflight), 32'd0);
        req0 = 1'b0;
        op0 = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        mon_en = 1'b1;

        // Single op from requester 0: ops 1,0,0,1
        req0 = 1; op0 = 4'b1001;
        step();
        req0 = 0; op0 = '0;
        repeat (4) step();

        // Both requesters high for 6 cycles
        req0 = 1; op0 = 4'b0011;
        req1 = 1; op1 = 4'b1111;
        repeat (6) step();
        req0 = 0; req1 = 0;
        repeat (4) step();

        // req1 alone for 3 cycles, then both for 2
        req1 = 1; op1 = 4'b0110;
        repeat (3) step();
        req0 = 1; op0 = 4'b1010;
        repeat (2) step();
        req0 = 0; req1 = 0;
        repeat (4) step();

        // Stream of 4 ops from req0, then flush
        req0 = 1;
        for (int i = 0; i < 4; i++) begin
            op0 = 4'(i * 5 + 3);
            step();
        end
        flush_req = 1; allow = 0;
        op0 = 4'b1111;
        chk("fd_t0", 32'(flush_done), 32'd0);
        for (int k = 1; k <= LAT + 1; k++) begin
            step();
            chk("fd_low", 32'(flush_done), 32'd0);
        end
        step();
        chk("fd_high", 32'(flush_done), 32'd1);
        step();
        chk("fd_hold", 32'(flush_done), 32'd1);
        flush_req = 0;
        step();
        allow = 1;
        chk("fd_clear", 32'(flush_done), 32'd0);
        step();
        req0 = 0;
        repeat (5) step();

        // Reset pulse with 2 ops in flight
        req0 = 1; op0 = 4'b0101;
        step();
        req0 = 0; req1 = 1; op1 = 4'b1000;
        step();
        req1 = 0; req0 = 1;
        #1 rst_n = 1'b0;
        #1;
        chk("arst_gnt", 32'({gnt0, gnt1}), 32'd0);
        chk("arst_dp", 32'({dp_a, dp_b, dp_c, dp_d}), 32'd0);
        chk("arst_rv", 32'({rvalid0, rvalid1}), 32'd0);
        chk("arst_rdata", 32'(rdata), 32'd0);
        chk("arst_fd", 32'(flush_done), 32'd0);
        chk("arst_inflight", 32'(inflight), 32'd0);
        q.delete();
        mptr = 1'b0;
        req0 = 0;
        #1 rst_n = 1'b1;
        repeat (6) step();

        // LAT=1 instance: single op
        req0_l1 = 1; op0_l1 = 4'b1001;
        #4;
        chk("l1_gnt0", 32'(gnt0_l1), 32'd1);
        step();
        req0_l1 = 0; op0_l1 = '0;
        chk("l1_rv_early", 32'(rvalid0_l1), 32'd0);
        chk("l1_inflight", 32'(inflight_l1), 32'd1);
        step();
        chk("l1_rv", 32'({rvalid0_l1, rvalid1_l1}), 32'b10);
        chk("l1_rdata", 32'(rdata_l1), 32'd1);
        step();
        chk("l1_rv_end", 32'(rvalid0_l1), 32'd0);
        chk("l1_inflight_end", 32'(inflight_l1), 32'd0);

        chk("sb_empty", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/simple_logic_ff_arb.md
# simple_logic_ff_arb

Round-robin arbiter and sequencer that shares one registered `simple_logic_ff` datapath, computing out = (a|b)&(c|d) with 2-cycle latency, between two requesters. Each cycle it grants at most one requester and drives that requester's operands onto the datapath inputs. A tag pipeline tracks in-flight operations, so each result returns registered to the requester that issued it. A drain/flush FSM quiesces the datapath before reconfiguration or power-down.

## Interface
- `LAT`, 2: datapath latency in clock edges, input sampled to `dp_out` valid; legal range 1..8.
- `clk`  in  1  rising-edge clock, shared with the datapath.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `req0`, `req1`  in  1  request; held high with stable operands until granted.
- `a0`,`b0`,`c0`,`d0` / `a1`,`b1`,`c1`,`d1`  in  1 each  operands for requester 0 / 1.
- `gnt0`, `gnt1`  out  1  combinational grant; operands consumed at this edge.
- `rvalid0`, `rvalid1`  out  1  registered one-cycle result strobe per requester.
- `rdata`  out  1  registered result, shared; meaningful only with an `rvalid*`.
- `dp_a`,`dp_b`,`dp_c`,`dp_d`  out  1 each  datapath operand inputs, combinational.
- `dp_out`  in  1  datapath result.
- `flush_req`  in  1  level; requests drain.
- `flush_done`  out  1  registered; high while drained and `flush_req` is still high.
- `inflight`  out  4  registered count of issued, unreturned operations.

## Operation
- The clock is a single clock, `clk`. Reset `rst_n` is asynchronous and active-low.
- FSM states are RUN, DRAIN, and FLUSHED. Reset state is RUN.
- RUN
  - Arbitrate.
  - If `flush_req`=1, go to DRAIN on the next edge. No grant is issued in the cycle `flush_req` is first seen.
- DRAIN
  - No grants.
  - When `inflight`=0 and no result is pending in the output register, go to FLUSHED.
- FLUSHED
  - `flush_done`=1, no grants.
  - When `flush_req`=0, go to RUN.
- Arbitration, RUN only
  - Priority pointer `ptr`, reset 0.
  - One requester high: grant it.
  - Both high: grant `req[ptr]`.
  - After any grant, `ptr` becomes the index of the non-granted requester.
- Operand mux
  - `dp_*` carry the granted requester's operands.
  - With no grant, `dp_*` are 0.
- Tag pipeline
  - LAT-deep shift register of {valid, id}, advancing every edge.
  - The stage-0 input is {grant, granted id}.
  - At the tail: if valid, register `rdata`<=`dp_out` and pulse `rvalid[id]`.
  - If tail valid=0, `rvalid*`<=0 and `rdata` holds its previous value.
- Inflight counter
  - +1 on grant, -1 on `rvalid*` pulse; both in one cycle leaves it unchanged.
  - Maximum LAT+1, no overflow possible.
- Datapath registers have no reset. Their post-reset contents are ignored because every tag valid is 0.
- Reset mid-operation clears the tags, `ptr`, the FSM, and all outputs.
  - Results in flight are dropped; no `rvalid` is produced for them.

## Timing
- Reset values: `gnt*`=0, `rvalid*`=0, `rdata`=0, `dp_*`=0, `flush_done`=0, `inflight`=0, state RUN, `ptr`=0.
- Grant in cycle t, so operands are sampled at edge t. `dp_out` is valid in cycle t+LAT. `rvalid`/`rdata` are high in cycle t+LAT+1.
  - End-to-end request latency is LAT+1 cycles, 3 at default.
- Throughput is one operation per cycle. Results return in issue order.
- Handshake
  - A requester holding `req` high sees `gnt` in the same cycle it is chosen.
  - It may drop `req` or present new operands in the following cycle.
- `flush_req` raised in cycle t: last possible grant is cycle t-1. `flush_done` rises no earlier than t+LAT+2.
- `flush_req` dropped while in DRAIN
  - The FSM still completes DRAIN, then FLUSHED.
  - It returns to RUN on the edge after FLUSHED is entered, because `flush_req`=0.

## Test plan
- Reset, then `req0`=1 with a0..d0=1,0,0,1 in cycle 1:
  - `gnt0`=1 in cycle 1;
  - `rvalid0`=1, `rdata`=1 in cycle 4;
  - `inflight` 1 from cycle 2 until `rvalid0` clears it.
- Both requesters high for 6 cycles, req0 ops=0,0,1,1, req1 ops=1,1,1,1:
  - grants alternate 0,1,0,1,0,1;
  - `rvalid` alternate from cycle 4;
  - `rdata`=0 for requester 0, 1 for requester 1.
- Only `req1` high for 3 cycles, then both high:
  - three `gnt1` pulses;
  - the first contended cycle grants 0 (`ptr`=0 after last gnt1);
  - no cycle with two grants.
- Back-to-back stream of 4 ops from req0, then `flush_req`=1 in cycle 5:
  - no grant in cycles 5+;
  - all 4 `rvalid0` arrive;
  - `flush_done`=1 once `inflight`=0 (cycle 9 at default LAT);
  - dropping `flush_req` restores grants one cycle later.
- `rst_n` pulsed low for a partial cycle with 2 ops in flight:
  - all outputs 0 asynchronously;
  - no `rvalid` after release;
  - `inflight`=0.
- LAT=1 build, single op in cycle 1 → `rvalid` in cycle 3 with the correct `rdata`.
